// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI/TLBWR from WB, owns CP0 Random, returns CP0 update pulses.
// Define TLB_OP_PERF_CNT_EN to add the perf_op_cnt completed-op counter port.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    output logic        done_valid,
    input  logic        done_ready,
    input  logic [4:0]  cp0_wired,
    input  logic        wired_we,
    input  logic [31:0] tlbp_index,
    input  logic [89:0] tlbr_tlb,
    output logic [31:0] cp0_random,
    output logic        tlbwi,
    output logic        tlbwr,
    output logic        index_we,
    output logic [31:0] index_wdata,
    output logic        tlbr_we,
    output logic [31:0] entryhi_wdata,
    output logic [31:0] pagemask_wdata,
    output logic [31:0] entrylo0_wdata,
    output logic [31:0] entrylo1_wdata
`ifdef TLB_OP_PERF_CNT_EN
    ,
    output logic [31:0] perf_op_cnt
`endif
);
    localparam int RW = $clog2(TLB_ENTRIES);
    localparam logic [RW-1:0] RAND_MAX = RW'(TLB_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state, state_n;
    logic [1:0]      op_q;
    logic            resp_first;
    logic [RW-1:0]   random;

    assign cp0_random = 32'(random);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        op_ready   = 1'b0;
        done_valid = 1'b0;
        tlbwi      = 1'b0;
        tlbwr      = 1'b0;
        index_we   = 1'b0;
        tlbr_we    = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                state_n  = op_valid ? ISSUE : IDLE;
            end
            ISSUE: begin
                tlbwi   = op_q == 2'b10;
                tlbwr   = op_q == 2'b11;
                state_n = RESP;
            end
            RESP: begin
                done_valid = 1'b1;
                index_we   = resp_first && op_q == 2'b00;
                tlbr_we    = resp_first && op_q == 2'b01;
                state_n    = done_ready ? IDLE : RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    // Random only advances on idle cycles with no accept, so TLBWR hits the slot seen at accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q           <= 2'b00;
            resp_first     <= 1'b0;
            random         <= RAND_MAX;
            index_wdata    <= '0;
            entryhi_wdata  <= '0;
            pagemask_wdata <= '0;
            entrylo0_wdata <= '0;
            entrylo1_wdata <= '0;
        end else begin
            resp_first <= state == ISSUE;
            if (state == IDLE && op_valid)
                op_q <= op_code;
            if (wired_we)
                random <= RAND_MAX;
            else if (state == IDLE && !op_valid)
                random <= (5'(random) <= cp0_wired) ? RAND_MAX : random - RW'(1);
            if (state == ISSUE && op_q == 2'b00)
                index_wdata <= tlbp_index;
            if (state == ISSUE && op_q == 2'b01) begin
                entryhi_wdata  <= {tlbr_tlb[89:71], 5'b0, tlbr_tlb[70:63]};
                pagemask_wdata <= {7'b0, tlbr_tlb[62:51], 13'b0};
                entrylo0_wdata <= {6'b0, tlbr_tlb[49:25], tlbr_tlb[50]};
                entrylo1_wdata <= {6'b0, tlbr_tlb[24:0], tlbr_tlb[50]};
            end
        end
    end

`ifdef TLB_OP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn)                      perf_op_cnt <= '0;
        else if (done_valid && done_ready) perf_op_cnt <= perf_op_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed stimulus against a cycle-count model of the TLB op sequencer.
module tb_tlb_op_ctrl;
    logic        clk = 1'b0;
    logic        resetn, op_valid, done_ready, wired_we;
    logic [1:0]  op_code;
    logic [4:0]  cp0_wired;
    logic [31:0] tlbp_index;
    logic [89:0] tlbr_tlb;
    logic        op_ready, done_valid, tlbwi, tlbwr, index_we, tlbr_we;
    logic [31:0] cp0_random, index_wdata, entryhi_wdata, pagemask_wdata, entrylo0_wdata, entrylo1_wdata;

    tlb_op_ctrl #(.TLB_ENTRIES(32)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .done_valid(done_valid), .done_ready(done_ready), .cp0_wired(cp0_wired), .wired_we(wired_we),
        .tlbp_index(tlbp_index), .tlbr_tlb(tlbr_tlb), .cp0_random(cp0_random), .tlbwi(tlbwi),
        .tlbwr(tlbwr), .index_we(index_we), .index_wdata(index_wdata), .tlbr_we(tlbr_we),
        .entryhi_wdata(entryhi_wdata), .pagemask_wdata(pagemask_wdata),
        .entrylo0_wdata(entrylo0_wdata), .entrylo1_wdata(entrylo1_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Model: m_cnt counts cycles since accept (0 = idle, 1 = strobe cycle, >=2 = completion pending)
    int          m_cnt = 0;
    int          m_rnd = 31;
    logic [1:0]  m_op = 2'b00;
    logic [31:0] m_idx = '0, m_eh = '0, m_pm = '0, m_lo0 = '0, m_lo1 = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_cnt = 0; m_rnd = 31; m_op = 2'b00;
            m_idx = '0; m_eh = '0; m_pm = '0; m_lo0 = '0; m_lo1 = '0;
        end else begin
            if (wired_we)
                m_rnd = 31;
            else if (m_cnt == 0 && !op_valid)
                m_rnd = (m_rnd <= int'(cp0_wired)) ? 31 : m_rnd - 1;
            if (m_cnt == 1 && m_op == 2'b00)
                m_idx = tlbp_index;
            if (m_cnt == 1 && m_op == 2'b01) begin
                m_eh  = (32'(tlbr_tlb[89:71]) << 13) | 32'(tlbr_tlb[70:63]);
                m_pm  = 32'(tlbr_tlb[62:51]) << 13;
                m_lo0 = (32'(tlbr_tlb[49:25]) << 1) | 32'(tlbr_tlb[50]);
                m_lo1 = (32'(tlbr_tlb[24:0]) << 1) | 32'(tlbr_tlb[50]);
            end
            if (m_cnt == 0) begin
                if (op_valid) begin m_cnt = 1; m_op = op_code; end
            end else if (m_cnt == 1 || !done_ready) m_cnt = m_cnt + 1;
            else m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("op_ready", 32'(op_ready), 32'(m_cnt == 0));
            chk("done_valid", 32'(done_valid), 32'(m_cnt >= 2));
            chk("tlbwi", 32'(tlbwi), 32'(m_cnt == 1 && m_op == 2'b10));
            chk("tlbwr", 32'(tlbwr), 32'(m_cnt == 1 && m_op == 2'b11));
            chk("index_we", 32'(index_we), 32'(m_cnt == 2 && m_op == 2'b00));
            chk("tlbr_we", 32'(tlbr_we), 32'(m_cnt == 2 && m_op == 2'b01));
            chk("cp0_random", cp0_random, 32'(m_rnd));
            chk("index_wdata", index_wdata, m_idx);
            chk("entryhi", entryhi_wdata, m_eh);
            chk("pagemask", pagemask_wdata, m_pm);
            chk("entrylo0", entrylo0_wdata, m_lo0);
            chk("entrylo1", entrylo1_wdata, m_lo1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_save;
    bit found;

    initial begin
        resetn = 1'b0; op_valid = 1'b0; done_ready = 1'b0; wired_we = 1'b0;
        op_code = 2'b00; cp0_wired = 5'd0; tlbp_index = '0; tlbr_tlb = '0;
        step(); step();
        check_en = 1'b1;
        resetn = 1'b1;
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rand_seq", cp0_random, 32'(31 - i));
            chk("rand_seq_no_strobe", 32'({tlbwi, tlbwr, index_we, tlbr_we}), 32'd0);
            step();
        end

        // TLBWI with done_ready held high
        op_valid = 1'b1; op_code = 2'b10; done_ready = 1'b1;
        step();
        op_valid = 1'b0;
        chk("wi_n1_tlbwi", 32'(tlbwi), 32'd1);
        chk("wi_n1_ready", 32'(op_ready), 32'd0);
        chk("wi_n1_done", 32'(done_valid), 32'd0);
        step();
        chk("wi_n2_tlbwi", 32'(tlbwi), 32'd0);
        chk("wi_n2_done", 32'(done_valid), 32'd1);
        step();
        chk("wi_n3_ready", 32'(op_ready), 32'd1);
        chk("wi_n3_done", 32'(done_valid), 32'd0);

        // TLBP with done_ready stalled 4 cycles
        op_valid = 1'b1; op_code = 2'b00; done_ready = 1'b0; tlbp_index = 32'h8000_0000;
        step();
        op_valid = 1'b0;
        step();
        chk("tlbp_we", 32'(index_we), 32'd1);
        chk("tlbp_wdata", index_wdata, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tlbp_hold_done", 32'(done_valid), 32'd1);
            chk("tlbp_no_second_we", 32'(index_we), 32'd0);
        end
        done_ready = 1'b1;
        step();
        chk("tlbp_back_idle", 32'(op_ready), 32'd1);

        // TLBR field unpack
        tlbr_tlb = {19'h12345, 8'h5A, 12'h003, 1'b1, 25'h0ABCDE7, 25'h1234567};
        op_valid = 1'b1; op_code = 2'b01;
        step();
        op_valid = 1'b0;
        step();
        chk("tlbr_we", 32'(tlbr_we), 32'd1);
        chk("tlbr_entryhi", entryhi_wdata, 32'h2468_A05A);
        chk("tlbr_pagemask", pagemask_wdata, 32'h0000_6000);
        chk("tlbr_entrylo0", entrylo0_wdata, 32'h0157_9BCF);
        chk("tlbr_entrylo1", entrylo1_wdata, 32'h0246_8ACF);
        step();

        // Wired = 8: random 9 -> 8 -> 31
        cp0_wired = 5'd8;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (cp0_random == 32'd9) found = 1;
            else step();
        end
        chk("wired_reach9", 32'(found), 32'd1);
        step();
        chk("wired_rand8", cp0_random, 32'd8);
        step();
        chk("wired_rand31", cp0_random, 32'd31);
        step(); step();

        // wired_we during RESP reloads and freezes random
        op_valid = 1'b1; op_code = 2'b10; done_ready = 1'b0;
        step();
        op_valid = 1'b0;
        step();
        wired_we = 1'b1;
        step();
        wired_we = 1'b0;
        chk("wwe_rand31", cp0_random, 32'd31);
        step();
        chk("wwe_frozen", cp0_random, 32'd31);
        done_ready = 1'b1;
        step();
        chk("wwe_idle31", cp0_random, 32'd31);
        step();
        chk("wwe_dec30", cp0_random, 32'd30);

        // TLBWR uses the slot visible at accept, then reset in ISSUE aborts it
        step();
        r_save = cp0_random;
        op_valid = 1'b1; op_code = 2'b11;
        step();
        op_valid = 1'b0;
        chk("wr_tlbwr", 32'(tlbwr), 32'd1);
        chk("wr_slot", cp0_random, r_save);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("abort_tlbwr", 32'(tlbwr), 32'd0);
        chk("abort_done", 32'(done_valid), 32'd0);
        chk("abort_idle", 32'(op_ready), 32'd1);
        chk("abort_rand", cp0_random, 32'd31);
        step();
        chk("abort_no_strobe", 32'({tlbwr, done_valid}), 32'd0);

        // Wired at max holds random at 31
        cp0_wired = 5'd31;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wired_max_hold", cp0_random, 32'd31);
        end
        step(); step();
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
